toll_collector: RTL and testbench

//  Sequential payment stage directly downstream of the combinational toll-classification block.

---
 rtl/toll_collector.sv | 228 ++++++++++++++++++++++
 tb/tb_toll_collector.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/toll_collector.sv
// Toll booth payment controller: latches the vehicle class fee, collects coins, returns change,
// opens the gate and raises an alarm. Define TOLL_VIOL_CNT_EN to add the viol_count output.
module toll_collector #(
    parameter int CW       = 8,
    parameter int HIGH_FEE = 100,
    parameter int MED_FEE  = 50,
    parameter int LOW_FEE  = 25,
    parameter int TIMEOUT  = 1000
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          car_arrive,
    input  logic          high,
    input  logic          med,
    input  logic          low,
    input  logic          err,
    input  logic          coin_valid,
    input  logic [1:0]    coin_val,
    input  logic          car_clear,
    input  logic          attn_clr,
    output logic          gate_open,
    output logic [CW-1:0] due,
    output logic          change_vld,
    output logic [CW-1:0] change_amt,
    output logic          coin_rej,
    output logic          alarm,
    output logic [15:0]   veh_count
`ifdef TOLL_VIOL_CNT_EN
    ,
    output logic [7:0]    viol_count
`endif
);

    // state   | meaning
    // IDLE    | waiting for a classified vehicle
    // COLLECT | accumulating coins toward the latched fee
    // OPEN    | paid, gate open until the vehicle clears
    // ALARM   | class error or payment timeout, waits for attendant
    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] COLLECT = 2'd1;
    localparam logic [1:0] OPEN    = 2'd2;
    localparam logic [1:0] ALARM   = 2'd3;

    localparam int TW = $clog2(TIMEOUT);
    localparam logic [TW-1:0] TMR_LOAD = TW'(TIMEOUT - 1);
    localparam logic [CW-1:0] HIGH_F   = CW'(HIGH_FEE);
    localparam logic [CW-1:0] MED_F    = CW'(MED_FEE);
    localparam logic [CW-1:0] LOW_F    = CW'(LOW_FEE);

    logic [1:0]    state_q, state_d;
    logic [CW-1:0] fee_q, fee_d;
    logic [CW-1:0] credit_q, credit_d;
    logic [TW-1:0] timer_q, timer_d;
    logic          gate_open_q, gate_open_d;
    logic [CW-1:0] due_q, due_d;
    logic          change_vld_q, change_vld_d;
    logic [CW-1:0] change_amt_q, change_amt_d;
    logic          coin_rej_q, coin_rej_d;
    logic          alarm_q, alarm_d;
    logic [15:0]   veh_count_q, veh_count_d;

    logic [CW-1:0] coin_amt;
    logic [CW-1:0] fee_sel;
    logic          class_ok;
    logic [CW:0]   sum;
    logic [CW:0]   over;

    always_comb begin
        coin_amt = CW'(5);
        case (coin_val)
            2'b00:   coin_amt = CW'(5);
            2'b01:   coin_amt = CW'(10);
            2'b10:   coin_amt = CW'(25);
            default: coin_amt = CW'(50);
        endcase
    end

    always_comb begin
        class_ok = 1'b0;
        fee_sel  = LOW_F;
        case ({high, med, low})
            3'b100:  begin class_ok = ~err; fee_sel = HIGH_F; end
            3'b010:  begin class_ok = ~err; fee_sel = MED_F;  end
            3'b001:  begin class_ok = ~err; fee_sel = LOW_F;  end
            default: class_ok = 1'b0;
        endcase
    end

    // One extra bit so an overpayment near the top of the range cannot wrap below the fee.
    assign sum  = {1'b0, credit_q} + {1'b0, coin_amt};
    assign over = sum - {1'b0, fee_q};

    always_comb begin
        state_d      = state_q;
        fee_d        = fee_q;
        credit_d     = credit_q;
        timer_d      = timer_q;
        gate_open_d  = gate_open_q;
        due_d        = due_q;
        change_vld_d = 1'b0;
        change_amt_d = change_amt_q;
        coin_rej_d   = 1'b0;
        alarm_d      = alarm_q;
        veh_count_d  = veh_count_q;

        case (state_q)
            IDLE: begin
                coin_rej_d = coin_valid;
                if (car_arrive) begin
                    if (class_ok) begin
                        fee_d    = fee_sel;
                        due_d    = fee_sel;
                        credit_d = '0;
                        timer_d  = TMR_LOAD;
                        state_d  = COLLECT;
                    end else begin
                        alarm_d      = 1'b1;
                        change_amt_d = '0;
                        state_d      = ALARM;
                    end
                end
            end
            COLLECT: begin
                if (coin_valid) begin
                    timer_d = TMR_LOAD;
                    if (sum >= {1'b0, fee_q}) begin
                        gate_open_d  = 1'b1;
                        change_vld_d = 1'b1;
                        change_amt_d = over[CW-1:0];
                        due_d        = '0;
                        credit_d     = '0;
                        state_d      = OPEN;
                    end else begin
                        credit_d = sum[CW-1:0];
                        due_d    = fee_q - sum[CW-1:0];
                    end
                end else if (timer_q == '0) begin
                    // Timeout refunds whatever was inserted; a zero refund is not pulsed.
                    alarm_d      = 1'b1;
                    due_d        = '0;
                    change_vld_d = (credit_q != '0);
                    change_amt_d = credit_q;
                    credit_d     = '0;
                    state_d      = ALARM;
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end
            OPEN: begin
                coin_rej_d = coin_valid;
                if (car_clear) begin
                    gate_open_d = 1'b0;
                    veh_count_d = veh_count_q + 16'd1;
                    state_d     = IDLE;
                end
            end
            default: begin
                coin_rej_d  = coin_valid;
                gate_open_d = 1'b0;
                if (attn_clr) begin
                    alarm_d = 1'b0;
                    state_d = IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            fee_q        <= '0;
            credit_q     <= '0;
            timer_q      <= '0;
            gate_open_q  <= 1'b0;
            due_q        <= '0;
            change_vld_q <= 1'b0;
            change_amt_q <= '0;
            coin_rej_q   <= 1'b0;
            alarm_q      <= 1'b0;
            veh_count_q  <= '0;
        end else begin
            state_q      <= state_d;
            fee_q        <= fee_d;
            credit_q     <= credit_d;
            timer_q      <= timer_d;
            gate_open_q  <= gate_open_d;
            due_q        <= due_d;
            change_vld_q <= change_vld_d;
            change_amt_q <= change_amt_d;
            coin_rej_q   <= coin_rej_d;
            alarm_q      <= alarm_d;
            veh_count_q  <= veh_count_d;
        end
    end

    assign gate_open  = gate_open_q;
    assign due        = due_q;
    assign change_vld = change_vld_q;
    assign change_amt = change_amt_q;
    assign coin_rej   = coin_rej_q;
    assign alarm      = alarm_q;
    assign veh_count  = veh_count_q;

`ifdef TOLL_VIOL_CNT_EN
    logic [7:0] viol_q, viol_d;

    // Counts vehicles crossing the sensor without a paid gate; attendant clear wins.
    always_comb begin
        viol_d = viol_q;
        if (attn_clr) begin
            viol_d = '0;
        end else if (car_clear && (state_q != OPEN) && (viol_q != 8'hFF)) begin
            viol_d = viol_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            viol_q <= '0;
        end else begin
            viol_q <= viol_d;
        end
    end

    assign viol_count = viol_q;
`endif

endmodule

// File: tb/tb_toll_collector.sv
// Self-checking bench for toll_collector: directed scenarios plus randomized traffic
// compared against a transaction-level model of the booth.
module tb_toll_collector;

    localparam int CW  = 8;
    localparam int TMO = 16;

    localparam int M_IDLE = 0;
    localparam int M_COLL = 1;
    localparam int M_OPEN = 2;
    localparam int M_ALRM = 3;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          car_arrive = 1'b0, high = 1'b0, med = 1'b0, low = 1'b0, err = 1'b0;
    logic          coin_valid = 1'b0;
    logic [1:0]    coin_val = 2'b00;
    logic          car_clear = 1'b0, attn_clr = 1'b0;
    logic          gate_open, change_vld, coin_rej, alarm;
    logic [CW-1:0] due, change_amt;
    logic [15:0]   veh_count;
`ifdef TOLL_VIOL_CNT_EN
    logic [7:0]    viol_count;
`endif

    int n_checks = 0;
    int n_err    = 0;

    int coin_tab [4] = '{5, 10, 25, 50};

    // reference model
    int m_mode, m_fee, m_credit, m_idle, m_veh, m_viol;
    int e_gate, e_due, e_cv, e_ca, e_rej, e_alarm;

    toll_collector #(.CW(CW), .HIGH_FEE(100), .MED_FEE(50), .LOW_FEE(25), .TIMEOUT(TMO)) dut (
        .clk(clk), .rst_n(rst_n), .car_arrive(car_arrive), .high(high), .med(med), .low(low),
        .err(err), .coin_valid(coin_valid), .coin_val(coin_val), .car_clear(car_clear),
        .attn_clr(attn_clr), .gate_open(gate_open), .due(due), .change_vld(change_vld),
        .change_amt(change_amt), .coin_rej(coin_rej), .alarm(alarm), .veh_count(veh_count)
`ifdef TOLL_VIOL_CNT_EN
        , .viol_count(viol_count)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic m_reset();
        m_mode = M_IDLE; m_fee = 0; m_credit = 0; m_idle = 0; m_veh = 0; m_viol = 0;
        e_gate = 0; e_due = 0; e_cv = 0; e_ca = 0; e_rej = 0; e_alarm = 0;
    endtask

    task automatic model_step(input logic a, h, m, l, e, cv, input logic [1:0] cval,
                              input logic cc, ac);
        int prev;
        int v;
        int ncls;
        prev  = m_mode;
        v     = coin_tab[cval];
        ncls  = int'(h) + int'(m) + int'(l);
        e_cv  = 0;
        e_rej = 0;
        case (m_mode)
            M_IDLE: begin
                if (cv) e_rej = 1;
                if (a) begin
                    if (!e && ncls == 1) begin
                        m_fee = h ? 100 : (m ? 50 : 25);
                        m_credit = 0; m_idle = 0; e_due = m_fee; m_mode = M_COLL;
                    end else begin
                        m_mode = M_ALRM; e_alarm = 1; e_ca = 0;
                    end
                end
            end
            M_COLL: begin
                if (cv) begin
                    m_idle = 0;
                    if (m_credit + v >= m_fee) begin
                        e_ca = m_credit + v - m_fee; e_cv = 1; e_gate = 1; e_due = 0;
                        m_credit = 0; m_mode = M_OPEN;
                    end else begin
                        m_credit = m_credit + v; e_due = m_fee - m_credit;
                    end
                end else begin
                    m_idle = m_idle + 1;
                    if (m_idle == TMO) begin
                        e_cv = (m_credit != 0) ? 1 : 0; e_ca = m_credit; m_credit = 0;
                        e_due = 0; e_alarm = 1; m_mode = M_ALRM;
                    end
                end
            end
            M_OPEN: begin
                if (cv) e_rej = 1;
                if (cc) begin
                    e_gate = 0; m_veh = (m_veh + 1) & 16'hFFFF; m_mode = M_IDLE;
                end
            end
            default: begin
                if (cv) e_rej = 1;
                e_gate = 0;
                if (ac) begin e_alarm = 0; m_mode = M_IDLE; end
            end
        endcase
        if (ac) m_viol = 0;
        else if (cc && prev != M_OPEN && m_viol < 255) m_viol = m_viol + 1;
    endtask

    task automatic step(input logic a, h, m, l, e, cv, input logic [1:0] cval,
                        input logic cc, ac);
        car_arrive = a; high = h; med = m; low = l; err = e;
        coin_valid = cv; coin_val = cval; car_clear = cc; attn_clr = ac;
        model_step(a, h, m, l, e, cv, cval, cc, ac);
        @(posedge clk);
        #1;
        car_arrive = 0; high = 0; med = 0; low = 0; err = 0;
        coin_valid = 0; coin_val = 0; car_clear = 0; attn_clr = 0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 2'd0, 0, 0);
    endtask

    task automatic test_reset();
        m_reset();
        #3;
        n_checks++; if ({gate_open, change_vld, coin_rej, alarm} !== 4'b0) begin n_err++;
            $display("FAIL reset_flags: got %b exp 0000", {gate_open, change_vld, coin_rej, alarm}); end
        n_checks++; if (due !== 8'd0 || change_amt !== 8'd0) begin n_err++;
            $display("FAIL reset_due_amt: got due=%0d amt=%0d exp 0/0", due, change_amt); end
        n_checks++; if (veh_count !== 16'd0) begin n_err++;
            $display("FAIL reset_veh: got %0d exp 0", veh_count); end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_exact_pay();
        step(1, 0, 1, 0, 0, 0, 2'd0, 0, 0);
        n_checks++; if (due !== 8'd50) begin n_err++; $display("FAIL exact_due0: got %0d exp 50", due); end
        step(0, 0, 0, 0, 0, 1, 2'd2, 0, 0);
        n_checks++; if (due !== 8'd25 || gate_open !== 1'b0) begin n_err++;
            $display("FAIL exact_due1: got due=%0d gate=%0d exp 25/0", due, gate_open); end
        step(0, 0, 0, 0, 0, 1, 2'd2, 0, 0);
        n_checks++; if ({gate_open, change_vld} !== 2'b11 || change_amt !== 8'd0 || due !== 8'd0) begin
            n_err++; $display("FAIL exact_paid: got gate=%0d vld=%0d amt=%0d due=%0d exp 1/1/0/0",
                              gate_open, change_vld, change_amt, due); end
        step(0, 0, 0, 0, 0, 0, 2'd0, 0, 0);
        n_checks++; if (change_vld !== 1'b0 || gate_open !== 1'b1) begin n_err++;
            $display("FAIL exact_hold: got vld=%0d gate=%0d exp 0/1", change_vld, gate_open); end
        step(0, 0, 0, 0, 0, 0, 2'd0, 1, 0);
        n_checks++; if (gate_open !== 1'b0 || veh_count !== 16'd1) begin n_err++;
            $display("FAIL exact_clear: got gate=%0d veh=%0d exp 0/1", gate_open, veh_count); end
    endtask

    task automatic test_overpay();
        step(1, 0, 0, 1, 0, 0, 2'd0, 0, 0);
        step(0, 0, 0, 0, 0, 1, 2'd3, 0, 0);
        n_checks++; if (change_vld !== 1'b1 || change_amt !== 8'd25 || gate_open !== 1'b1) begin
            n_err++; $display("FAIL overpay_change: got vld=%0d amt=%0d gate=%0d exp 1/25/1",
                              change_vld, change_amt, gate_open); end
        step(0, 0, 0, 0, 0, 1, 2'd1, 0, 0);
        n_checks++; if (coin_rej !== 1'b1) begin n_err++;
            $display("FAIL overpay_open_rej: got %0d exp 1", coin_rej); end
        step(0, 0, 0, 0, 0, 0, 2'd0, 1, 0);
        n_checks++; if (gate_open !== 1'b0 || veh_count !== 16'd2) begin n_err++;
            $display("FAIL overpay_clear: got gate=%0d veh=%0d exp 0/2", gate_open, veh_count); end
    endtask

    task automatic test_error();
        step(1, 1, 0, 0, 1, 0, 2'd0, 0, 0);
        n_checks++; if (alarm !== 1'b1 || change_vld !== 1'b0 || change_amt !== 8'd0) begin n_err++;
            $display("FAIL error_alarm: got alarm=%0d vld=%0d amt=%0d exp 1/0/0", alarm, change_vld, change_amt); end
        step(0, 0, 0, 0, 0, 1, 2'd1, 0, 0);
        n_checks++; if (coin_rej !== 1'b1 || alarm !== 1'b1) begin n_err++;
            $display("FAIL error_rej: got rej=%0d alarm=%0d exp 1/1", coin_rej, alarm); end
        step(1, 0, 1, 0, 0, 0, 2'd0, 0, 0);
        n_checks++; if (coin_rej !== 1'b0 || alarm !== 1'b1 || due !== 8'd0) begin n_err++;
            $display("FAIL error_ignore: got rej=%0d alarm=%0d due=%0d exp 0/1/0", coin_rej, alarm, due); end
        step(0, 0, 0, 0, 0, 0, 2'd0, 0, 1);
        n_checks++; if (alarm !== 1'b0) begin n_err++; $display("FAIL error_clr: got %0d exp 0", alarm); end
        step(1, 1, 1, 0, 0, 0, 2'd0, 0, 0);
        n_checks++; if (alarm !== 1'b1) begin n_err++; $display("FAIL error_twohot: got %0d exp 1", alarm); end
        step(0, 0, 0, 0, 0, 0, 2'd0, 0, 1);
    endtask

    task automatic test_timeout();
        step(1, 1, 0, 0, 0, 0, 2'd0, 0, 0);
        step(0, 0, 0, 0, 0, 1, 2'd1, 0, 0);
        n_checks++; if (due !== 8'd90) begin n_err++; $display("FAIL timeout_due: got %0d exp 90", due); end
        idle(TMO - 1);
        n_checks++; if (alarm !== 1'b0) begin n_err++; $display("FAIL timeout_early: got %0d exp 0", alarm); end
        idle(1);
        n_checks++; if (alarm !== 1'b1 || change_vld !== 1'b1 || change_amt !== 8'd10 || due !== 8'd0) begin
            n_err++; $display("FAIL timeout_refund: got alarm=%0d vld=%0d amt=%0d due=%0d exp 1/1/10/0",
                              alarm, change_vld, change_amt, due); end
        step(0, 0, 0, 0, 0, 0, 2'd0, 0, 1);
        // coin arriving in the would-be timeout cycle restarts the timer
        step(1, 0, 0, 1, 0, 0, 2'd0, 0, 0);
        idle(TMO - 1);
        step(0, 0, 0, 0, 0, 1, 2'd0, 0, 0);
        n_checks++; if (alarm !== 1'b0 || due !== 8'd20) begin n_err++;
            $display("FAIL timeout_coin_wins: got alarm=%0d due=%0d exp 0/20", alarm, due); end
        idle(TMO - 1);
        n_checks++; if (alarm !== 1'b0) begin n_err++; $display("FAIL timeout_restart: got %0d exp 0", alarm); end
        idle(1);
        n_checks++; if (alarm !== 1'b1 || change_vld !== 1'b1 || change_amt !== 8'd5) begin n_err++;
            $display("FAIL timeout_refund5: got alarm=%0d vld=%0d amt=%0d exp 1/1/5", alarm, change_vld, change_amt); end
        step(0, 0, 0, 0, 0, 0, 2'd0, 0, 1);
        step(1, 0, 1, 0, 0, 0, 2'd0, 0, 0);
        idle(TMO);
        n_checks++; if (alarm !== 1'b1 || change_vld !== 1'b0) begin n_err++;
            $display("FAIL timeout_nocredit: got alarm=%0d vld=%0d exp 1/0", alarm, change_vld); end
        step(0, 0, 0, 0, 0, 0, 2'd0, 0, 1);
    endtask

    task automatic test_reset_mid();
        step(1, 1, 0, 0, 0, 0, 2'd0, 0, 0);
        step(0, 0, 0, 0, 0, 1, 2'd3, 0, 0);
        rst_n = 1'b0;
        #2;
        m_reset();
        n_checks++; if (due !== 8'd0 || veh_count !== 16'd0 || {gate_open, change_vld, alarm} !== 3'b0) begin
            n_err++; $display("FAIL reset_mid: got due=%0d veh=%0d gate=%0d exp 0/0/0", due, veh_count, gate_open); end
        #1;
        rst_n = 1'b1;
        step(1, 0, 0, 1, 0, 0, 2'd0, 0, 0);
        n_checks++; if (due !== 8'd25) begin n_err++; $display("FAIL reset_mid_due: got %0d exp 25", due); end
        step(0, 0, 0, 0, 0, 1, 2'd2, 0, 0);
        n_checks++; if (change_vld !== 1'b1 || change_amt !== 8'd0) begin n_err++;
            $display("FAIL reset_mid_credit_lost: got vld=%0d amt=%0d exp 1/0", change_vld, change_amt); end
        step(0, 0, 0, 0, 0, 0, 2'd0, 1, 0);
    endtask

`ifdef TOLL_VIOL_CNT_EN
    task automatic test_violation();
        step(0, 0, 0, 0, 0, 0, 2'd0, 0, 1);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 0, 2'd0, 1, 0);
        n_checks++; if (viol_count !== 8'd3) begin n_err++; $display("FAIL viol_count: got %0d exp 3", viol_count); end
        step(0, 0, 0, 0, 0, 0, 2'd0, 0, 1);
        n_checks++; if (viol_count !== 8'd0) begin n_err++; $display("FAIL viol_clr: got %0d exp 0", viol_count); end
    endtask
`endif

    task automatic test_random();
        logic a, h, m, l, e, cv, cc, ac;
        logic [1:0] cval;
        int r;
        for (int i = 0; i < 1200; i++) begin
            a  = ($urandom_range(0, 5) == 0);
            r  = $urandom_range(0, 7);
            h = 0; m = 0; l = 0; e = 0;
            if (r < 6) begin
                case ($urandom_range(0, 2))
                    0: h = 1;
                    1: m = 1;
                    default: l = 1;
                endcase
            end else begin
                {h, m, l} = 3'($urandom_range(0, 7));
                e = (r == 6);
            end
            cv   = ($urandom_range(0, (i < 600) ? 2 : 24) == 0);
            cval = 2'($urandom_range(0, 3));
            cc   = ($urandom_range(0, 4) == 0);
            ac   = ($urandom_range(0, 7) == 0);
            step(a, h, m, l, e, cv, cval, cc, ac);
            n_checks++; if (gate_open !== 1'(e_gate)) begin n_err++;
                $display("FAIL rnd_gate @%0d: got %0d exp %0d", i, gate_open, e_gate); end
            n_checks++; if (due !== CW'(e_due)) begin n_err++;
                $display("FAIL rnd_due @%0d: got %0d exp %0d", i, due, e_due); end
            n_checks++; if (change_vld !== 1'(e_cv) || change_amt !== CW'(e_ca)) begin n_err++;
                $display("FAIL rnd_change @%0d: got %0d/%0d exp %0d/%0d", i, change_vld, change_amt, e_cv, e_ca); end
            n_checks++; if (coin_rej !== 1'(e_rej)) begin n_err++;
                $display("FAIL rnd_rej @%0d: got %0d exp %0d", i, coin_rej, e_rej); end
            n_checks++; if (alarm !== 1'(e_alarm)) begin n_err++;
                $display("FAIL rnd_alarm @%0d: got %0d exp %0d", i, alarm, e_alarm); end
            n_checks++; if (veh_count !== 16'(m_veh)) begin n_err++;
                $display("FAIL rnd_veh @%0d: got %0d exp %0d", i, veh_count, m_veh); end
`ifdef TOLL_VIOL_CNT_EN
            n_checks++; if (viol_count !== 8'(m_viol)) begin n_err++;
                $display("FAIL rnd_viol @%0d: got %0d exp %0d", i, viol_count, m_viol); end
`endif
        end
    endtask

    initial begin
        test_reset();
        test_exact_pay();
        test_overpay();
        test_error();
        test_timeout();
        test_reset_mid();
`ifdef TOLL_VIOL_CNT_EN
        test_violation();
`endif
        test_random();
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
